// File: rtl/interrupt_vector_sequencer_if.sv
// Interface bundling the interrupt_vector_sequencer control and status signals.
//  slave  : the sequencer itself (decoder/pin inputs in, PC/stack/bus controls out)
//  master : the surrounding core (or a testbench) driving inputs and observing outputs
interface interrupt_vector_sequencer_if;
    logic       phase_2_rising;
    logic       nmi_n;
    logic       irq_n;
    logic       i_flag;
    logic       brk_req;
    logic       instr_boundary;
    logic       busy;
    logic       stack_dec;
    logic       push_pch;
    logic       push_pcl;
    logic       push_p;
    logic       write_en;
    logic       b_flag_out;
    logic       set_i_flag;
    logic       vec_ab_en;
    logic [7:0] vec_adl;
    logic [7:0] vec_adh;
    logic       adl_pcl;
    logic       adh_pch;
    logic       increment_pc;
    logic       done;

    modport slave (
        input  phase_2_rising, nmi_n, irq_n, i_flag, brk_req, instr_boundary,
        output busy, stack_dec, push_pch, push_pcl, push_p, write_en, b_flag_out,
        output set_i_flag, vec_ab_en, vec_adl, vec_adh, adl_pcl, adh_pch, increment_pc, done
    );

    modport master (
        output phase_2_rising, nmi_n, irq_n, i_flag, brk_req, instr_boundary,
        input  busy, stack_dec, push_pch, push_pcl, push_p, write_en, b_flag_out,
        input  set_i_flag, vec_ab_en, vec_adl, vec_adh, adl_pcl, adh_pch, increment_pc, done
    );
endinterface

// File: rtl/interrupt_vector_sequencer.sv
// 6502 reset/NMI/IRQ/BRK entry sequencer sitting directly upstream of the program counter.
// Walks DUMMY1..LOAD_PCH one state per machine cycle (phase_2_rising strobe), issuing the
// three stack pushes, the two vector fetches and the PC load controls.
//  sys_clock, reset : clock and asynchronous active-high reset
//  bus (slave)      : pins/decoder inputs, stack/bus/PC control outputs
module interrupt_vector_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  VEC_PAGE    = 8'hFF,
    parameter logic [7:0]  NMI_VEC_L   = 8'hFA,
    parameter logic [7:0]  RESET_VEC_L = 8'hFC,
    parameter logic [7:0]  IRQ_VEC_L   = 8'hFE
) (
    input logic                          sys_clock,
    input logic                          reset,
    interrupt_vector_sequencer_if.slave  bus
);
    typedef enum logic [3:0] {
        StIdle, StDummy1, StDummy2, StPushPch, StPushPcl, StPushP, StVecLo, StVecHi, StLoadPch
    } state_e;
    typedef enum logic [1:0] {SrcReset, SrcNmi, SrcIrq, SrcBrk} src_e;

    state_e state_q, state_d;
    src_e   src_q, src_d;
    logic   vec_nmi_q, vec_nmi_d;       // vector in use is NMI (taken or hijacked)
    logic   nmi_pending_q, nmi_pending_d;
    logic   nmi_prev_q;
    logic [SYNC_STAGES-1:0] nmi_sync_q, irq_sync_q;

    logic       busy_d, stack_dec_d, push_pch_d, push_pcl_d, push_p_d, write_en_d;
    logic       b_flag_d, set_i_d, vec_ab_en_d, adl_pcl_d, adh_pch_d, done_d;
    logic [7:0] vec_adl_d, vec_l;
    logic       nmi_s, irq_s, nmi_fall, pre_vec, vec_nmi_eff, enter_vec_lo, not_rst;

    // Synchronisers reset to the inactive (high) pin level so release never fakes an edge.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            nmi_sync_q <= '1;
            irq_sync_q <= '1;
            nmi_prev_q <= 1'b1;
        end else begin
            nmi_sync_q <= {nmi_sync_q[SYNC_STAGES-2:0], bus.nmi_n};
            irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], bus.irq_n};
            nmi_prev_q <= nmi_s;
        end
    end

    assign nmi_s    = nmi_sync_q[SYNC_STAGES-1];
    assign irq_s    = irq_sync_q[SYNC_STAGES-1];
    assign nmi_fall = nmi_prev_q & ~nmi_s;

    // A pending NMI seen before VEC_LO redirects an IRQ/BRK sequence to the NMI vector.
    assign pre_vec      = state_q inside {StDummy1, StDummy2, StPushPch, StPushPcl, StPushP};
    assign vec_nmi_eff  = vec_nmi_q | (nmi_pending_q & pre_vec & (src_q != SrcReset));
    assign enter_vec_lo = bus.phase_2_rising & (state_q == StPushP);
    // An edge in the clearing cycle survives because nmi_fall is ORed in after the clear.
    assign nmi_pending_d = nmi_fall | (nmi_pending_q & ~(enter_vec_lo & vec_nmi_eff));

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        vec_nmi_d = vec_nmi_eff;
        done_d    = 1'b0;
        if (bus.phase_2_rising) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.instr_boundary) begin
                        if (nmi_pending_q) begin
                            state_d   = StDummy1;
                            src_d     = SrcNmi;
                            vec_nmi_d = 1'b1;
                        end else if (!irq_s && !bus.i_flag) begin
                            state_d   = StDummy1;
                            src_d     = SrcIrq;
                            vec_nmi_d = 1'b0;
                        end else if (bus.brk_req) begin
                            state_d   = StDummy1;
                            src_d     = SrcBrk;
                            vec_nmi_d = 1'b0;
                        end
                    end
                end
                StDummy1:  state_d = StDummy2;
                StDummy2:  state_d = StPushPch;
                StPushPch: state_d = StPushPcl;
                StPushPcl: state_d = StPushP;
                StPushP:   state_d = StVecLo;
                StVecLo:   state_d = StVecHi;
                StVecHi:   state_d = StLoadPch;
                StLoadPch: begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
                default:   state_d = StIdle;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they change on the
    // advancing edge and hold for the whole machine cycle.
    always_comb begin
        not_rst     = (src_d != SrcReset);
        vec_l       = !not_rst ? RESET_VEC_L : (vec_nmi_d ? NMI_VEC_L : IRQ_VEC_L);
        busy_d      = (state_d != StIdle);
        stack_dec_d = state_d inside {StPushPch, StPushPcl, StPushP};
        push_pch_d  = (state_d == StPushPch) & not_rst;
        push_pcl_d  = (state_d == StPushPcl) & not_rst;
        push_p_d    = (state_d == StPushP) & not_rst;
        write_en_d  = stack_dec_d & not_rst;
        b_flag_d    = (src_d == SrcBrk) & busy_d;
        set_i_d     = (state_d == StVecLo);
        vec_ab_en_d = state_d inside {StVecLo, StVecHi};
        vec_adl_d   = (state_d == StVecHi) ? vec_l + 8'd1 : vec_l;
        adl_pcl_d   = (state_d == StVecHi);
        adh_pch_d   = (state_d == StLoadPch);
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state_q          <= StDummy1;
            src_q            <= SrcReset;
            vec_nmi_q        <= 1'b0;
            nmi_pending_q    <= 1'b0;
            bus.busy         <= 1'b1;
            bus.stack_dec    <= 1'b0;
            bus.push_pch     <= 1'b0;
            bus.push_pcl     <= 1'b0;
            bus.push_p       <= 1'b0;
            bus.write_en     <= 1'b0;
            bus.b_flag_out   <= 1'b0;
            bus.set_i_flag   <= 1'b0;
            bus.vec_ab_en    <= 1'b0;
            bus.vec_adl      <= RESET_VEC_L;
            bus.adl_pcl      <= 1'b0;
            bus.adh_pch      <= 1'b0;
            bus.increment_pc <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            state_q          <= state_d;
            src_q            <= src_d;
            vec_nmi_q        <= vec_nmi_d;
            nmi_pending_q    <= nmi_pending_d;
            bus.busy         <= busy_d;
            bus.stack_dec    <= stack_dec_d;
            bus.push_pch     <= push_pch_d;
            bus.push_pcl     <= push_pcl_d;
            bus.push_p       <= push_p_d;
            bus.write_en     <= write_en_d;
            bus.b_flag_out   <= b_flag_d;
            bus.set_i_flag   <= set_i_d;
            bus.vec_ab_en    <= vec_ab_en_d;
            bus.vec_adl      <= vec_adl_d;
            bus.adl_pcl      <= adl_pcl_d;
            bus.adh_pch      <= adh_pch_d;
            bus.increment_pc <= ~busy_d;
            bus.done         <= done_d;
        end
    end

    assign bus.vec_adh = VEC_PAGE;
endmodule

// File: tb/tb_interrupt_vector_sequencer.sv
// Directed bench for interrupt_vector_sequencer. Step index s names the state after a strobe:
// 0 DUMMY1, 1 DUMMY2, 2 PUSH_PCH, 3 PUSH_PCL, 4 PUSH_P, 5 VEC_LO, 6 VEC_HI, 7 LOAD_PCH,
// 8 IDLE (done pulse), 9 IDLE (quiet).
module tb_interrupt_vector_sequencer;
    logic sys_clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;

    interrupt_vector_sequencer_if bus();

    interrupt_vector_sequencer #(.SYNC_STAGES(2)) dut (
        .sys_clock (sys_clock),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 sys_clock = ~sys_clock;

    always @(posedge sys_clock) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

    // {busy, stack_dec, push_pch, push_pcl, push_p, write_en, b_flag_out, set_i_flag,
    //  vec_ab_en, adl_pcl, adh_pch, increment_pc, done}
    function automatic logic [12:0] obs_flags();
        return {bus.busy, bus.stack_dec, bus.push_pch, bus.push_pcl, bus.push_p, bus.write_en,
                bus.b_flag_out, bus.set_i_flag, bus.vec_ab_en, bus.adl_pcl, bus.adh_pch,
                bus.increment_pc, bus.done};
    endfunction

    // Expected flag word for step s; r = reset source, b = BRK.
    function automatic logic [12:0] exp_flags(int s, bit r, bit b);
        logic [12:0] e;
        e[12] = (s <= 7);
        e[11] = (s >= 2 && s <= 4);
        e[10] = (s == 2) && !r;
        e[9]  = (s == 3) && !r;
        e[8]  = (s == 4) && !r;
        e[7]  = (s >= 2 && s <= 4) && !r;
        e[6]  = b && (s <= 7);
        e[5]  = (s == 5);
        e[4]  = (s == 5 || s == 6);
        e[3]  = (s == 6);
        e[2]  = (s == 7);
        e[1]  = (s >= 8);
        e[0]  = (s == 8);
        return e;
    endfunction

    task automatic clocks(int n);
        repeat (n) @(posedge sys_clock);
        #1;
    endtask

    // One machine cycle: two quiet clocks, then a one-clock phase_2_rising strobe.
    task automatic mc(bit bnd);
        repeat (2) @(posedge sys_clock);
        @(negedge sys_clock);
        bus.phase_2_rising = 1'b1;
        bus.instr_boundary = bnd;
        @(posedge sys_clock);
        #1;
        bus.phase_2_rising = 1'b0;
        bus.instr_boundary = 1'b0;
    endtask

    task automatic test_reset();
        int d0;
        logic [7:0] vl;
        total++;
        if (obs_flags() !== 13'b1_0000_0000_0000 || bus.vec_adl !== 8'hFC ||
            bus.vec_adh !== 8'hFF) begin
            bad++;
            $display("FAIL reset_state got flags=%b adl=%h adh=%h want flags=%b adl=fc adh=ff",
                     obs_flags(), bus.vec_adl, bus.vec_adh, 13'b1_0000_0000_0000);
        end
        @(negedge sys_clock);
        reset = 1'b0;
        d0 = done_cnt;
        for (int s = 1; s <= 9; s++) begin
            mc(1'b0);
            total++;
            if (obs_flags() !== exp_flags(s, 1'b1, 1'b0)) begin
                bad++;
                $display("FAIL reset_seq step %0d got %b want %b", s, obs_flags(),
                         exp_flags(s, 1'b1, 1'b0));
            end
            if (s == 5 || s == 6) begin
                vl = (s == 5) ? 8'hFC : 8'hFD;
                total++;
                if (bus.vec_adl !== vl) begin
                    bad++;
                    $display("FAIL reset_vec step %0d got %h want %h", s, bus.vec_adl, vl);
                end
            end
        end
        total++;
        if (done_cnt - d0 !== 1) begin
            bad++;
            $display("FAIL reset_done_count got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_irq();
        logic [7:0] vl;
        bus.irq_n  = 1'b0;
        bus.i_flag = 1'b0;
        clocks(3);
        mc(1'b1);
        bus.irq_n = 1'b1;
        for (int s = 0; s <= 9; s++) begin
            if (s > 0) mc(1'b0);
            total++;
            if (obs_flags() !== exp_flags(s, 1'b0, 1'b0)) begin
                bad++;
                $display("FAIL irq_seq step %0d got %b want %b", s, obs_flags(),
                         exp_flags(s, 1'b0, 1'b0));
            end
            if (s == 5 || s == 6) begin
                vl = (s == 5) ? 8'hFE : 8'hFF;
                total++;
                if (bus.vec_adl !== vl) begin
                    bad++;
                    $display("FAIL irq_vec step %0d got %h want %h", s, bus.vec_adl, vl);
                end
            end
        end
        // Masked IRQ must leave the sequencer idle.
        bus.irq_n  = 1'b0;
        bus.i_flag = 1'b1;
        clocks(3);
        mc(1'b1);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL irq_masked busy got %b want 0", bus.busy);
        end
        bus.irq_n  = 1'b1;
        bus.i_flag = 1'b0;
        clocks(3);
    endtask

    task automatic test_priority();
        logic [7:0] vl;
        // IRQ beats BRK.
        bus.irq_n   = 1'b0;
        bus.brk_req = 1'b1;
        clocks(3);
        mc(1'b1);
        bus.irq_n   = 1'b1;
        bus.brk_req = 1'b0;
        for (int s = 0; s <= 9; s++) begin
            if (s > 0) mc(1'b0);
            total++;
            if (obs_flags() !== exp_flags(s, 1'b0, 1'b0)) begin
                bad++;
                $display("FAIL irq_over_brk step %0d got %b want %b", s, obs_flags(),
                         exp_flags(s, 1'b0, 1'b0));
            end
        end
        // BRK alone.
        clocks(3);
        bus.brk_req = 1'b1;
        mc(1'b1);
        bus.brk_req = 1'b0;
        for (int s = 0; s <= 9; s++) begin
            if (s > 0) mc(1'b0);
            total++;
            if (obs_flags() !== exp_flags(s, 1'b0, 1'b1)) begin
                bad++;
                $display("FAIL brk_seq step %0d got %b want %b", s, obs_flags(),
                         exp_flags(s, 1'b0, 1'b1));
            end
            if (s == 5 || s == 6) begin
                vl = (s == 5) ? 8'hFE : 8'hFF;
                total++;
                if (bus.vec_adl !== vl) begin
                    bad++;
                    $display("FAIL brk_vec step %0d got %h want %h", s, bus.vec_adl, vl);
                end
            end
        end
    endtask

    task automatic test_nmi_hijack();
        logic [7:0] vl;
        bus.brk_req = 1'b1;
        mc(1'b1);
        bus.brk_req = 1'b0;
        for (int s = 0; s <= 9; s++) begin
            if (s > 0) mc(1'b0);
            if (s == 3) bus.nmi_n = 1'b0;
            total++;
            if (obs_flags() !== exp_flags(s, 1'b0, 1'b1)) begin
                bad++;
                $display("FAIL hijack_seq step %0d got %b want %b", s, obs_flags(),
                         exp_flags(s, 1'b0, 1'b1));
            end
            if (s == 5 || s == 6) begin
                vl = (s == 5) ? 8'hFA : 8'hFB;
                total++;
                if (bus.vec_adl !== vl) begin
                    bad++;
                    $display("FAIL hijack_vec step %0d got %h want %h", s, bus.vec_adl, vl);
                end
            end
        end
        bus.nmi_n = 1'b1;
        clocks(3);
        // Pending was consumed by the hijack: the next boundary finds nothing to take.
        mc(1'b1);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL hijack_no_second_nmi busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_nmi_pending();
        logic [7:0] vl;
        bus.nmi_n = 1'b0;
        clocks(3);
        bus.nmi_n = 1'b1;
        mc(1'b0);
        mc(1'b0);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL nmi_wait_boundary busy got %b want 0", bus.busy);
        end
        mc(1'b1);
        for (int s = 0; s <= 9; s++) begin
            if (s > 0) mc(1'b0);
            total++;
            if (obs_flags() !== exp_flags(s, 1'b0, 1'b0)) begin
                bad++;
                $display("FAIL nmi_seq step %0d got %b want %b", s, obs_flags(),
                         exp_flags(s, 1'b0, 1'b0));
            end
            if (s == 5 || s == 6) begin
                vl = (s == 5) ? 8'hFA : 8'hFB;
                total++;
                if (bus.vec_adl !== vl) begin
                    bad++;
                    $display("FAIL nmi_vec step %0d got %h want %h", s, bus.vec_adl, vl);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        bus.irq_n = 1'b0;
        clocks(3);
        mc(1'b1);
        for (int s = 1; s <= 4; s++) mc(1'b0);
        total++;
        if (bus.push_p !== 1'b1 || bus.write_en !== 1'b1) begin
            bad++;
            $display("FAIL abort_in_push_p push_p=%b write_en=%b want 1 1", bus.push_p,
                     bus.write_en);
        end
        @(negedge sys_clock);
        reset = 1'b1;
        #1;
        total++;
        if (obs_flags() !== exp_flags(0, 1'b1, 1'b0) || bus.vec_adl !== 8'hFC) begin
            bad++;
            $display("FAIL abort_reset_state got flags=%b adl=%h want flags=%b adl=fc",
                     obs_flags(), bus.vec_adl, exp_flags(0, 1'b1, 1'b0));
        end
        bus.irq_n = 1'b1;
        clocks(2);
        @(negedge sys_clock);
        reset = 1'b0;
        for (int s = 1; s <= 9; s++) begin
            mc(1'b0);
            total++;
            if (obs_flags() !== exp_flags(s, 1'b1, 1'b0)) begin
                bad++;
                $display("FAIL abort_reseq step %0d got %b want %b", s, obs_flags(),
                         exp_flags(s, 1'b1, 1'b0));
            end
        end
    endtask

    initial begin
        reset              = 1'b1;
        bus.phase_2_rising = 1'b0;
        bus.nmi_n          = 1'b1;
        bus.irq_n          = 1'b1;
        bus.i_flag         = 1'b0;
        bus.brk_req        = 1'b0;
        bus.instr_boundary = 1'b0;
        clocks(3);
        test_reset();
        test_irq();
        test_priority();
        test_nmi_hijack();
        test_nmi_pending();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
